// File: rtl/float_pkg.sv
// Shared constants and types for the binary32 <-> int32 conversion blocks.
package float_pkg;

  // binary32 field layout
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = FRAC_W + 1;

  // Exponent landmarks
  localparam logic [EXP_W-1:0] EXP_BIAS    = 8'd127;
  localparam logic [EXP_W-1:0] EXP_OFFSET  = EXP_BIAS + 8'(FRAC_W);  // 150: mantissa LSB has weight 1
  localparam logic [EXP_W-1:0] EXP_SAT     = EXP_BIAS + 8'd31;       // 158: magnitude >= 2^31
  localparam logic [EXP_W-1:0] EXP_HALF    = EXP_BIAS - 8'd1;        // 126: magnitude in [0.5, 1)
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;                  // inf / NaN

  // Integer saturation limits
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // -2^31 is representable exactly and must not be reported as saturated
  localparam logic [31:0] X_NEG_2P31 = 32'hCF00_0000;

  // Conversion status reported with each result
  typedef enum logic [1:0] {
    STATUS_EXACT   = 2'b00,
    STATUS_INEXACT = 2'b01,
    STATUS_SAT     = 2'b10,
    STATUS_INVALID = 2'b11
  } status_e;

  // Overflow code delivered by the upstream float adder
  typedef enum logic [1:0] {
    OVF_NONE    = 2'b00,
    OVF_UPPER   = 2'b01,
    OVF_UNDER   = 2'b10,
    OVF_SPECIAL = 2'b11
  } ovf_e;

  // Converter sequencing
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    SHIFT  = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/rne_round.sv
// Round-to-nearest-even of an aligned magnitude plus guard/sticky, then apply sign.
module rne_round (
  input  logic [31:0] mag,
  input  logic        guard,
  input  logic        sticky,
  input  logic        sign,
  output logic [31:0] q,
  output logic        inexact
);

  logic        inc;
  logic [31:0] rounded;

  // Round up when above half, or exactly half with an odd LSB; then negate if needed
  always_comb begin
    inc     = guard & (sticky | mag[0]);
    rounded = mag + {31'd0, inc};
    q       = sign ? (~rounded + 32'd1) : rounded;
    inexact = guard | sticky;
  end

endmodule

// File: rtl/float_to_int.sv
// Iterative binary32 -> saturated int32 converter, one alignment bit per cycle.
module float_to_int
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [1:0]  in_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic [1:0]  status
);

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d;
  ovf_e        flag_q, flag_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic [31:0] q_q, q_d;
  status_e     status_q, status_d;
  logic        out_valid_q, out_valid_d;

  // Field decode of the captured operand
  logic                  sign_w;
  logic [EXP_W-1:0]      exp_w;
  logic [FRAC_W-1:0]     frac_w;
  logic [MANT_W-1:0]     mant_w;
  logic [EXP_W-1:0]      shift_w;
  logic [31:0]           sat_w;
  logic                  is_nan_w;
  logic                  is_inf_w;

  assign sign_w   = x_q[31];
  assign exp_w    = x_q[30:23];
  assign frac_w   = x_q[22:0];
  assign mant_w   = {exp_w != 8'd0, frac_w};
  assign shift_w  = (exp_w >= EXP_OFFSET) ? (exp_w - EXP_OFFSET) : (EXP_OFFSET - exp_w);
  assign sat_w    = sign_w ? INT_MIN : INT_MAX;
  assign is_nan_w = (exp_w == EXP_SPECIAL) && (frac_w != '0);
  assign is_inf_w = (exp_w == EXP_SPECIAL) && (frac_w == '0);

  logic [31:0] rnd_q;
  logic        rnd_inexact;

  rne_round u_rne_round (
    .mag     (mag_q),
    .guard   (guard_q),
    .sticky  (sticky_q),
    .sign    (sign_w),
    .q       (rnd_q),
    .inexact (rnd_inexact)
  );

  // State and datapath registers; reset aborts any operation in flight
  // NOTE: sequential state uses non-blocking assignment so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      flag_q      <= OVF_NONE;
      mag_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      q_q         <= '0;
      status_q    <= STATUS_EXACT;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      flag_q      <= flag_d;
      mag_q       <= mag_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      q_q         <= q_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update for each phase of the conversion
  // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    flag_d      = flag_q;
    mag_d       = mag_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    q_d         = q_q;
    status_d    = status_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          flag_d  = ovf_e'(in_flag);
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        if (is_nan_w) begin
          q_d      = INT_MIN;
          status_d = STATUS_INVALID;
          state_d  = DONE;
        end else if (is_inf_w || (flag_q == OVF_UPPER)) begin
          q_d      = sat_w;
          status_d = STATUS_SAT;
          state_d  = DONE;
        end else if (exp_w >= EXP_SAT) begin
          q_d      = sat_w;
          status_d = (x_q == X_NEG_2P31) ? STATUS_EXACT : STATUS_SAT;
          state_d  = DONE;
        end else if (exp_w < EXP_HALF) begin
          // Magnitude below one half always rounds to zero
          q_d      = '0;
          status_d = (x_q[30:0] == 31'd0) ? STATUS_EXACT : STATUS_INEXACT;
          state_d  = DONE;
        end else begin
          mag_d    = {8'd0, mant_w};
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          cnt_d    = 5'(shift_w);
          left_d   = (exp_w >= EXP_OFFSET);
          state_d  = (shift_w == 8'd0) ? ROUND : SHIFT;
        end
      end

      SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[30:0], 1'b0};
        end else begin
          sticky_d = sticky_q | guard_q;
          guard_d  = mag_q[0];
          mag_d    = {1'b0, mag_q[31:1]};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        q_d      = rnd_q;
        status_d = rnd_inexact ? STATUS_INEXACT : STATUS_EXACT;
        state_d  = DONE;
      end

      DONE: begin
        // First DONE cycle raises out_valid; the result is then held until taken
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign status    = status_q;

endmodule

// File: tb/tb_float_to_int.sv
// Self-checking bench for float_to_int: directed vectors, random vs. model, handshake, reset.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [1:0]  in_flag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q;
  logic [1:0]  status;

  int errors = 0;
  int checks = 0;

  float_to_int dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .in_flag   (in_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .status    (status)
  );

  always #5 clk = ~clk;

  // Reference: exact arithmetic on m * 2^(e-150), RNE by comparing the remainder with one half
  function automatic void ref_model(input logic [31:0] xv, input logic [1:0] fl,
                                    output logic [31:0] eq, output logic [1:0] es, output int el);
    logic   s;
    int     e, kk;
    longint m, ip, rem, half, v;
    s  = xv[31];
    e  = int'(xv[30:23]);
    m  = longint'(xv[22:0]);
    if (e != 0) m = m + (longint'(1) << 23);
    el = 2;
    if (e == 255 && xv[22:0] != 0) begin
      eq = 32'h8000_0000; es = 2'b11;
    end else if (e == 255 || fl == 2'b01) begin
      eq = s ? 32'h8000_0000 : 32'h7FFF_FFFF; es = 2'b10;
    end else if (e >= 158) begin
      // magnitude is at least 2^31; only -2^31 itself fits
      if (s && e == 158 && xv[22:0] == 0) begin
        eq = 32'h8000_0000; es = 2'b00;
      end else begin
        eq = s ? 32'h8000_0000 : 32'h7FFF_FFFF; es = 2'b10;
      end
    end else if (e < 126) begin
      eq = '0; es = (xv[30:0] == 0) ? 2'b00 : 2'b01;
    end else begin
      if (e >= 150) begin
        ip  = m << (e - 150);
        rem = 0;
        el  = 3 + (e - 150);
      end else begin
        kk   = 150 - e;
        ip   = m >> kk;
        rem  = m - (ip << kk);
        half = longint'(1) << (kk - 1);
        if (rem > half || (rem == half && ip[0])) ip = ip + 1;
        el   = 3 + kk;
      end
      v  = s ? -ip : ip;
      eq = v[31:0];
      es = (rem != 0) ? 2'b01 : 2'b00;
    end
  endfunction

  function automatic logic [31:0] rand_x();
    int          c, sh;
    logic [7:0]  e;
    logic [22:0] f;
    c  = $urandom_range(0, 9);
    f  = 23'($urandom);
    sh = $urandom_range(0, 23);
    f  = (f >> sh) << sh;   // trailing zeros make exact ties likely
    case (c)
      0:       return $urandom;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(0, 125));
      default: e = 8'($urandom_range(126, 160));
    endcase
    return {1'($urandom), e, f};
  endfunction

  function automatic logic [1:0] rand_flag();
    int t;
    if ($urandom_range(0, 7) == 0) return 2'b01;
    t = $urandom_range(0, 2);
    return (t == 0) ? 2'b00 : ((t == 1) ? 2'b10 : 2'b11);
  endfunction

  // Drive one operand, wait (bounded) for the result, sample it, then consume it
  task automatic run_op(input logic [31:0] xv, input logic [1:0] fl,
                        output logic [31:0] oq, output logic [1:0] os,
                        output int lat, output bit ok);
    bit rdy;
    @(negedge clk);
    rdy      = in_ready;
    in_valid = 1'b1;
    x        = xv;
    in_flag  = fl;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x        = $urandom;
    in_flag  = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ok = rdy && out_valid;
    oq = q;
    os = status;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (q !== 32'd0)       begin errors++; $display("FAIL reset_q: got %h want 00000000", q); end
    checks++; if (status !== 2'b00)  begin errors++; $display("FAIL reset_status: got %b want 00", status); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b1;
  endtask

  typedef struct packed {
    logic [31:0] x;
    logic [1:0]  fl;
    logic [31:0] q;
    logic [1:0]  st;
    logic [7:0]  lat;
  } vec_t;

  task automatic test_directed();
    vec_t        vecs [14];
    logic [31:0] oq;
    logic [1:0]  os;
    int          lat;
    bit          ok;
    vecs = '{
      '{32'h3FC0_0000, 2'b00, 32'd2,          2'b01, 8'd26},
      '{32'h4020_0000, 2'b00, 32'd2,          2'b01, 8'd25},
      '{32'hC060_0000, 2'b00, 32'hFFFF_FFFC,  2'b01, 8'd25},
      '{32'h4B00_0001, 2'b00, 32'd8388609,    2'b00, 8'd3},
      '{32'h4EFF_FFFF, 2'b00, 32'h7FFF_FF80,  2'b00, 8'd10},
      '{32'h4F00_0000, 2'b00, 32'h7FFF_FFFF,  2'b10, 8'd2},
      '{32'hCF00_0000, 2'b00, 32'h8000_0000,  2'b00, 8'd2},
      '{32'hFF80_0000, 2'b00, 32'h8000_0000,  2'b10, 8'd2},
      '{32'h7FC0_0000, 2'b00, 32'h8000_0000,  2'b11, 8'd2},
      '{32'h3F80_0000, 2'b01, 32'h7FFF_FFFF,  2'b10, 8'd2},
      '{32'h0000_0000, 2'b00, 32'd0,          2'b00, 8'd2},
      '{32'h0000_0001, 2'b00, 32'd0,          2'b01, 8'd2},
      '{32'h3F00_0000, 2'b00, 32'd0,          2'b01, 8'd27},
      '{32'h3F00_0001, 2'b00, 32'd1,          2'b01, 8'd27}
    };
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].x, vecs[i].fl, oq, os, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL dir%0d_handshake: x=%h got no result want result", i, vecs[i].x); end
      checks++; if (oq !== vecs[i].q) begin errors++; $display("FAIL dir%0d_q: x=%h got %h want %h", i, vecs[i].x, oq, vecs[i].q); end
      checks++; if (os !== vecs[i].st) begin errors++; $display("FAIL dir%0d_status: x=%h got %b want %b", i, vecs[i].x, os, vecs[i].st); end
      checks++; if (lat !== int'(vecs[i].lat)) begin errors++; $display("FAIL dir%0d_latency: x=%h got %0d want %0d", i, vecs[i].x, lat, vecs[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] xv, oq, eq;
    logic [1:0]  fl, os, es;
    int          lat, el;
    bit          ok;
    for (int i = 0; i < 150; i++) begin
      xv = rand_x();
      fl = rand_flag();
      ref_model(xv, fl, eq, es, el);
      run_op(xv, fl, oq, os, lat, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_handshake: x=%h flag=%b got no result want result", xv, fl); end
      checks++; if (oq !== eq) begin errors++; $display("FAIL rnd_q: x=%h flag=%b got %h want %h", xv, fl, oq, eq); end
      checks++; if (os !== es) begin errors++; $display("FAIL rnd_status: x=%h flag=%b got %b want %b", xv, fl, os, es); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd_latency: x=%h flag=%b got %0d want %0d", xv, fl, lat, el); end
    end
  endtask

  task automatic test_handshake();
    logic [31:0] oq;
    logic [1:0]  os;
    int          lat;
    bit          ok;
    @(negedge clk);
    in_valid = 1'b1;
    x        = 32'h4040_0000;
    in_flag  = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hs_first_valid: got %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        x        = 32'h3F80_0000;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hs_hold_valid%0d: got %b want 1", i, out_valid); end
      checks++; if (q !== 32'd3) begin errors++; $display("FAIL hs_hold_q%0d: got %h want 00000003", i, q); end
      checks++; if (status !== 2'b00) begin errors++; $display("FAIL hs_hold_status%0d: got %b want 00", i, status); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hs_hold_in_ready%0d: got %b want 0", i, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hs_release_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hs_release_in_ready: got %b want 1", in_ready); end
    run_op(32'hC060_0000, 2'b00, oq, os, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hs_next_handshake: got no result want result"); end
    checks++; if (oq !== 32'hFFFF_FFFC) begin errors++; $display("FAIL hs_next_q: got %h want fffffffc", oq); end
    checks++; if (os !== 2'b01) begin errors++; $display("FAIL hs_next_status: got %b want 01", os); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xv, eq;
    logic [1:0]  fl, es;
    int          lat, el;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      xv = rand_x();
      fl = rand_flag();
      ref_model(xv, fl, eq, es, el);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, in_ready); end
      in_valid = 1'b1;
      x        = xv;
      in_flag  = fl;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      checks++; if (q !== eq) begin errors++; $display("FAIL b2b_q%0d: x=%h got %h want %h", i, xv, q, eq); end
      checks++; if (status !== es) begin errors++; $display("FAIL b2b_status%0d: x=%h got %b want %b", i, xv, status, es); end
      checks++; if (lat !== el) begin errors++; $display("FAIL b2b_latency%0d: x=%h got %0d want %0d", i, xv, lat, el); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_consumed%0d: got %b want 0", i, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] oq;
    logic [1:0]  os;
    int          lat;
    bit          ok;
    run_op(32'h4B00_0001, 2'b00, oq, os, lat, ok);
    checks++; if (oq !== 32'd8388609) begin errors++; $display("FAIL rst_pre_q: got %h want 00800001", oq); end
    @(negedge clk);
    in_valid = 1'b1;
    x        = 32'h3FC0_0000;
    in_flag  = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (q !== 32'd0)        begin errors++; $display("FAIL rst_mid_q: got %h want 00000000", q); end
    checks++; if (status !== 2'b00)   begin errors++; $display("FAIL rst_mid_status: got %b want 00", status); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_discard: got %b want 0", out_valid); end
    run_op(32'h4040_0000, 2'b00, oq, os, lat, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_after_handshake: got no result want result"); end
    checks++; if (oq !== 32'd3) begin errors++; $display("FAIL rst_after_q: got %h want 00000003", oq); end
    checks++; if (os !== 2'b00) begin errors++; $display("FAIL rst_after_status: got %b want 00", os); end
    checks++; if (lat !== 25) begin errors++; $display("FAIL rst_after_latency: got %0d want 25", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so a stuck design cannot hang the run
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/float_to_int.md
# float_to_int

Multi-cycle converter that takes the single-precision result and overflow code from the float adder and produces a saturated signed 32-bit integer. It rounds to nearest, ties to even, and reports an exactness/saturation status. The block sits directly downstream of the adder in the ALU datapath and uses a valid/ready handshake on both sides. Alignment is iterative, one bit per cycle, in the same style as the adder's alignment loop.

## Interface
- No parameters; widths fixed (IEEE-754 binary32 in, int32 out).
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept; high only in IDLE.
- x  in  32  binary32 operand (adder z).
- in_flag  in  2  adder overflow code: 00 none, 01 upper overflow, 10 underflow, 11 NaN/inf.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer accepts result.
- q  out  32  signed two's-complement result.
- status  out  2  00 exact, 01 inexact (rounded), 10 saturated, 11 invalid (NaN).

## Operation
- States: IDLE, UNPACK, SHIFT, ROUND, DONE.
- IDLE → UNPACK on in_valid && in_ready; x and in_flag are registered.
- UNPACK decodes s=x[31], e=x[30:23], f=x[22:0]. Mantissa m = {e!=0, f} (24 bits); value = m·2^(e−150).
- UNPACK special cases, each going straight to DONE:
  - NaN (e==255, f!=0): q=0x80000000, status 11.
  - Inf (e==255, f==0) or in_flag==01: q = s ? 0x80000000 : 0x7FFFFFFF, status 10.
  - e≥158: same saturation, status 10. Exception: x==0xCF000000 gives q=0x80000000, status 00.
  - e<126 (covers zero and denormals): q=0; status 00 if e==0 && f==0, else 01.
- UNPACK normal case: mag={8'b0,m}, guard=0, sticky=0, cnt=|e−150|, dir=(e≥150 ? left : right). Goes to SHIFT if cnt≠0, otherwise ROUND.
- SHIFT, one bit per cycle, cnt decrements:
  - Left: mag<<=1. Always exact; max e=157 gives mag<2^31.
  - Right: sticky|=guard, guard=mag[0], mag>>=1.
  - Leaves for ROUND when cnt reaches 1→0.
- ROUND: inc = guard && (sticky || mag[0]); r = mag+inc (cannot exceed 2^31−1). q = s ? −r : r. status = (guard||sticky) ? 01 : 00. Goes to DONE.
- DONE: out_valid=1, q and status held stable. When out_ready is high, go to IDLE and clear out_valid on that edge.
- in_flag 10 and 11 do not override; the encoding of x decides.

## Timing
- Reset values: q=0, status=00, out_valid=0, in_ready=1, state=IDLE, internal registers 0.
- Reset asserted mid-operation aborts immediately and discards the operand.
- Latency is counted from the accept edge k:
  - Special cases: out_valid high after edge k+2.
  - Normal: out_valid high after edge k+3+n, with n=|e−150|, 0..24; worst case 27 cycles.
- Throughput: one operation in flight. in_ready=0 from UNPACK through DONE.
- The earliest next accept is the edge after the one on which DONE is consumed.
- in_valid and x are ignored while busy.
- out_valid never drops without out_ready.
- q and status change only on the UNPACK→DONE or ROUND→DONE transition.

## Structure
- Shared package float_pkg:
  - binary32 field widths and bias 127.
  - Constant 150 (bias+23).
  - Saturation constants 0x7FFFFFFF and 0x80000000.
  - status codes and the adder overflow codes.
  - State enum.
- One sub-module, rne_round: combinational; inputs mag/guard/sticky/sign; outputs q/inexact. Also reused later by int_to_float.
- Everything else lives in one always_ff FSM plus a next-state block.

## Test plan
- Rounding:
  - 0x3FC00000 (1.5) → q=2, status 01, out_valid 26 cycles after accept.
  - 0x40200000 (2.5) → q=2, status 01.
  - 0xC0600000 (−3.5) → q=0xFFFFFFFC, status 01.
- Exact/left shift:
  - 0x4B000001 → q=8388609, status 00, latency 3.
  - 0x4EFFFFFF → q=0x7FFFFF80, status 00, latency 10.
- Saturation/invalid:
  - 0x4F000000 → 0x7FFFFFFF, status 10.
  - 0xCF000000 → 0x80000000, status 00.
  - 0xFF800000 → 0x80000000, status 10.
  - 0x7FC00000 → 0x80000000, status 11.
  - x=0x3F800000 with in_flag=01 → 0x7FFFFFFF, status 10.
- Small values:
  - 0x00000000 → 0, status 00.
  - 0x00000001 → 0, status 01.
  - 0x3F000000 (0.5) → 0, status 01.
  - 0x3F000001 → 1, status 01.
- Handshake: hold out_ready=0 for 5 cycles in DONE → q, status and out_valid stable, in_ready=0, and a pulsed in_valid is not accepted. Raise out_ready → IDLE next edge, then accept a new operand.
- Reset: assert rst low during SHIFT of 1.5 → outputs go to reset values immediately. After release, 0x40400000 → q=3, status 00.
